id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register plus operand-forwarding and load-use hazard logic for the pipelined MIPS core. It sits directly upstream of the ALU. It captures decoded operands and control each cycle, and resolves RAW hazards by forwarding from EX/MEM and MEM/WB. It drives the ALU's A, B and ALUcon inputs, and stalls decode for one cycle on a load-use hazard.

## Interface
Parameters:
- `DW`, 32, datapath width
- `RW`, 5, register-index width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `id_valid`  in  1  decode holds a real instruction
- `id_rs`, `id_rt`, `id_rd`  in  RW each  source/dest register indices
- `id_rs_data`, `id_rt_data`  in  DW each  register-file read data
- `id_imm`  in  DW  sign/zero-extended immediate
- `id_use_imm`  in  1  B operand is `id_imm` instead of rt
- `id_alucon`  in  4  ALU operation code
- `id_reg_write`, `id_mem_read`  in  1 each  control bits
- `flush`  in  1  branch/jump squash of the instruction entering EX
- `mem_rd`, `mem_reg_write`, `mem_result`  in  RW/1/DW  EX/MEM forwarding source
- `wb_rd`, `wb_reg_write`, `wb_result`  in  RW/1/DW  MEM/WB forwarding source
- `alu_a`, `alu_b`  out  DW each  ALU operands
- `alu_con`  out  4  ALU operation
- `ex_valid`, `ex_rd`, `ex_reg_write`, `ex_mem_read`  out  1/RW/1/1  EX-stage control to EX/MEM
- `ex_rt_fwd`  out  DW  forwarded rt value (store data)
- `stall`  out  1  hold PC and IF/ID this cycle

## Operation
- **Registered state:** valid, rs, rt, rd, rs_data, rt_data, imm, use_imm, alucon, reg_write, mem_read.
- **Load-use detect (combinational):**
  - `stall` = `id_valid` & `ex_valid` & `ex_mem_read` & (`ex_rd` != 0) & (`ex_rd` == `id_rs` | (`ex_rd` == `id_rt` & !`id_use_imm`)).
- **Register update, priority order:**
  1. `flush`: load a bubble (valid, reg_write, mem_read = 0; other fields don't-care, held at 0).
  2. `stall`: load a bubble. Decode holds its own state externally.
  3. Otherwise: load all `id_*` fields. If `id_valid` = 0, reg_write and mem_read are forced to 0.
- **Forwarding, per source operand S ∈ {rs, rt}:**
  - If `mem_reg_write` & `mem_rd` != 0 & `mem_rd` == S → `mem_result`.
  - Else if `wb_reg_write` & `wb_rd` != 0 & `wb_rd` == S → `wb_result`.
  - Else the registered data.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- **Operand outputs:**
  - `alu_a` = forwarded rs.
  - `ex_rt_fwd` = forwarded rt.
  - `alu_b` = `imm` if `use_imm`, else forwarded rt.
- **Pass-through:** `alu_con` = registered alucon, passed through unmodified; codes 0000–1000 are defined by the ALU.
- **Bubble rule:** a bubble never writes or reads memory; its operand values are don't-care but deterministic.

## Timing
- Latency: one cycle from `id_*` inputs to EX outputs.
- Forwarding is combinational from the registered indices and the current-cycle `mem_*`/`wb_*` inputs; there is no added latency.
- `stall` is combinational from `id_*` and registered EX state, valid in the same cycle. It lasts exactly one cycle per load-use: the bubble clears `ex_mem_read` next cycle, and the load then forwards from MEM/WB.
- Simultaneous `flush` and `stall`: flush wins and `stall` is still asserted. Asserting `stall` is harmless, because the flushed decode slot is re-fetched.
- Reset (asynchronous on `rst_n` low, mid-operation included):
  - All registers clear to 0; `ex_valid` = 0, `ex_reg_write` = 0, `ex_mem_read` = 0, `alu_con` = 0000.
  - `alu_a`, `alu_b`, `ex_rt_fwd` = 0 unless a forward hits; no forward can hit register 0.
  - `stall` = 0.
- Release of reset: the first rising edge with `rst_n` high loads normally.

## Structure
- Shared package `mips_pkg`:
  - ALUCON code constants (ADD 0000 … MUL 1000)
  - `REG_ZERO` = 0
  - `DW`/`RW` defaults
  - forward-select enum {FWD_REG, FWD_MEM, FWD_WB}
- Sub-module `forward_unit`: combinational, instantiated twice (rs, rt). Inputs: index, registered data and both forward sources. Outputs: the selected value and its select code.
- Top level holds the pipeline register, hazard detect and the B-operand mux.

## Test plan
- **Plain issue:** `id_rs_data`=5, `id_rt_data`=7, `id_alucon`=0000, no forwards → next cycle `alu_a`=5, `alu_b`=7, `alu_con`=0000, `ex_valid`=1.
- **Forward priority:** EX rs=3; `mem_rd`=3, `mem_result`=0x11; `wb_rd`=3, `wb_result`=0x22; both write-enabled → `alu_a`=0x11. Drop `mem_reg_write` → `alu_a`=0x22.
- **Register 0:** EX rs=0, `mem_rd`=0, `mem_reg_write`=1, `mem_result`=0xFF → `alu_a` = registered data (0), no forward.
- **Load-use:** EX holds lw with rd=4; ID has rs=4 → `stall`=1 for exactly one cycle and EX receives a bubble (`ex_reg_write`=0). The next instruction then forwards `wb_result` for rs.
- **Immediate and store data:** `id_use_imm`=1, `id_imm`=0xFFFF_FFFC, rt forwarded from MEM = 9 → `alu_b`=0xFFFF_FFFC, `ex_rt_fwd`=9.
- **Flush and reset:** `flush` with a valid ID → `ex_valid`=0 next cycle. `rst_n` dropped asynchronously mid-stream → all EX outputs 0 before the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core constants, ALU codes and forward-select type
package mips_pkg;

   localparam int DW_DEF   = 32;
   localparam int RW_DEF   = 5;
   localparam int REG_ZERO = 0;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_NOR = 4'b0101;
   localparam logic [3:0] ALU_SLT = 4'b0110;
   localparam logic [3:0] ALU_SLL = 4'b0111;
   localparam logic [3:0] ALU_MUL = 4'b1000;

   typedef enum logic [1:0] {
      FWD_REG = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2
   } fwd_sel_e;

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - operand bypass select for one source register
module forward_unit
   import mips_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int RW = RW_DEF
) (
   input  logic [RW-1:0] idx,
   input  logic [DW-1:0] reg_data,
   input  logic [RW-1:0] mem_rd,
   input  logic          mem_reg_write,
   input  logic [DW-1:0] mem_result,
   input  logic [RW-1:0] wb_rd,
   input  logic          wb_reg_write,
   input  logic [DW-1:0] wb_result,
   output logic [DW-1:0] value,
   output fwd_sel_e      sel
);

   localparam logic [RW-1:0] ZERO_IDX = RW'(REG_ZERO);

   // EX/MEM is the younger producer, so it overrides MEM/WB.
   always_comb begin
      value = reg_data;
      sel   = FWD_REG;
      if (mem_reg_write && (mem_rd != ZERO_IDX) && (mem_rd == idx)) begin
         value = mem_result;
         sel   = FWD_MEM;
      end else if (wb_reg_write && (wb_rd != ZERO_IDX) && (wb_rd == idx)) begin
         value = wb_result;
         sel   = FWD_WB;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding and load-use stall
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int RW = RW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          id_valid,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_rd,
   input  logic [DW-1:0] id_rs_data,
   input  logic [DW-1:0] id_rt_data,
   input  logic [DW-1:0] id_imm,
   input  logic          id_use_imm,
   input  logic [3:0]    id_alucon,
   input  logic          id_reg_write,
   input  logic          id_mem_read,
   input  logic          flush,
   input  logic [RW-1:0] mem_rd,
   input  logic          mem_reg_write,
   input  logic [DW-1:0] mem_result,
   input  logic [RW-1:0] wb_rd,
   input  logic          wb_reg_write,
   input  logic [DW-1:0] wb_result,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [3:0]    alu_con,
   output logic          ex_valid,
   output logic [RW-1:0] ex_rd,
   output logic          ex_reg_write,
   output logic          ex_mem_read,
   output logic [DW-1:0] ex_rt_fwd,
   output logic          stall
);

   logic          valid_q, valid_d;
   logic [RW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
   logic [DW-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
   logic          use_imm_q, use_imm_d;
   logic [3:0]    alucon_q, alucon_d;
   logic          reg_write_q, reg_write_d, mem_read_q, mem_read_d;

   logic [DW-1:0] rs_fwd, rt_fwd;
   fwd_sel_e      rs_sel, rt_sel;

   always_comb begin
      stall = id_valid && valid_q && mem_read_q && (rd_q != '0) &&
              ((rd_q == id_rs) || ((rd_q == id_rt) && !id_use_imm));

      // A bubble is all-zero so its operands stay deterministic.
      valid_d     = 1'b0;
      rs_d        = '0;
      rt_d        = '0;
      rd_d        = '0;
      rs_data_d   = '0;
      rt_data_d   = '0;
      imm_d       = '0;
      use_imm_d   = 1'b0;
      alucon_d    = '0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      if (!flush && !stall) begin
         valid_d     = id_valid;
         rs_d        = id_rs;
         rt_d        = id_rt;
         rd_d        = id_rd;
         rs_data_d   = id_rs_data;
         rt_data_d   = id_rt_data;
         imm_d       = id_imm;
         use_imm_d   = id_use_imm;
         alucon_d    = id_alucon;
         reg_write_d = id_reg_write && id_valid;
         mem_read_d  = id_mem_read && id_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         rs_q        <= '0;
         rt_q        <= '0;
         rd_q        <= '0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         imm_q       <= '0;
         use_imm_q   <= 1'b0;
         alucon_q    <= ALU_ADD;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         rd_q        <= rd_d;
         rs_data_q   <= rs_data_d;
         rt_data_q   <= rt_data_d;
         imm_q       <= imm_d;
         use_imm_q   <= use_imm_d;
         alucon_q    <= alucon_d;
         reg_write_q <= reg_write_d;
         mem_read_q  <= mem_read_d;
      end
   end

   forward_unit #(.DW(DW), .RW(RW)) u_fwd_rs (
      .idx(rs_q), .reg_data(rs_data_q),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
      .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
      .value(rs_fwd), .sel(rs_sel)
   );

   forward_unit #(.DW(DW), .RW(RW)) u_fwd_rt (
      .idx(rt_q), .reg_data(rt_data_q),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
      .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
      .value(rt_fwd), .sel(rt_sel)
   );

   // Register 0 is hardwired, so a bypass onto it would be a decode bug.
   zero_not_fwd_a: assert property (@(posedge clk) disable iff (!rst_n)
      (rs_q != '0) || (rs_sel == FWD_REG));
   zero_not_fwd_b: assert property (@(posedge clk) disable iff (!rst_n)
      (rt_q != '0) || (rt_sel == FWD_REG));

   assign alu_a        = rs_fwd;
   assign ex_rt_fwd    = rt_fwd;
   assign alu_b        = use_imm_q ? imm_q : rt_fwd;
   assign alu_con      = alucon_q;
   assign ex_valid     = valid_q;
   assign ex_rd        = rd_q;
   assign ex_reg_write = reg_write_q;
   assign ex_mem_read  = mem_read_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int RW = 5;

   logic          clk, rst_n;
   logic          id_valid, id_use_imm, id_reg_write, id_mem_read, flush;
   logic [RW-1:0] id_rs, id_rt, id_rd, mem_rd, wb_rd;
   logic [DW-1:0] id_rs_data, id_rt_data, id_imm, mem_result, wb_result;
   logic [3:0]    id_alucon;
   logic          mem_reg_write, wb_reg_write;
   logic [DW-1:0] alu_a, alu_b, ex_rt_fwd;
   logic [3:0]    alu_con;
   logic          ex_valid, ex_reg_write, ex_mem_read, stall;
   logic [RW-1:0] ex_rd;

   id_ex_stage #(.DW(DW), .RW(RW)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_use_imm(id_use_imm), .id_alucon(id_alucon), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .flush(flush), .mem_rd(mem_rd),
      .mem_reg_write(mem_reg_write), .mem_result(mem_result), .wb_rd(wb_rd),
      .wb_reg_write(wb_reg_write), .wb_result(wb_result), .alu_a(alu_a), .alu_b(alu_b),
      .alu_con(alu_con), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_rt_fwd(ex_rt_fwd), .stall(stall)
   );

   typedef struct {
      string         name;
      logic [DW-1:0] a, b, rtf;
      logic [3:0]    con;
      logic          v, rw, mr, st;
      logic [RW-1:0] rd;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push_exp(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [3:0] con, input logic v, input logic [RW-1:0] rd,
                           input logic rw, input logic mr, input logic [DW-1:0] rtf,
                           input logic st);
      exp_t e;
      e.name = name; e.a = a; e.b = b; e.con = con; e.v = v; e.rd = rd;
      e.rw = rw; e.mr = mr; e.rtf = rtf; e.st = st;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                         input logic [RW-1:0] rd, input logic [DW-1:0] rsd,
                         input logic [DW-1:0] rtd, input logic [DW-1:0] imm,
                         input logic ui, input logic [3:0] con, input logic rw,
                         input logic mr);
      id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd;
      id_rt_data = rtd; id_imm = imm; id_use_imm = ui; id_alucon = con;
      id_reg_write = rw; id_mem_read = mr;
   endtask

   task automatic set_fwd(input logic [RW-1:0] mrd, input logic mrw, input logic [DW-1:0] mres,
                          input logic [RW-1:0] wrd, input logic wrw, input logic [DW-1:0] wres);
      mem_rd = mrd; mem_reg_write = mrw; mem_result = mres;
      wb_rd = wrd; wb_reg_write = wrw; wb_result = wres;
   endtask

   // Monitor: compares every cycle that has a pending expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if (alu_a !== e.a || alu_b !== e.b || alu_con !== e.con || ex_valid !== e.v ||
             ex_rd !== e.rd || ex_reg_write !== e.rw || ex_mem_read !== e.mr ||
             ex_rt_fwd !== e.rtf || stall !== e.st) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h con=%h v=%b rd=%0d rw=%b mr=%b rtf=%h st=%b; want a=%h b=%h con=%h v=%b rd=%0d rw=%b mr=%b rtf=%h st=%b",
                     e.name, alu_a, alu_b, alu_con, ex_valid, ex_rd, ex_reg_write,
                     ex_mem_read, ex_rt_fwd, stall, e.a, e.b, e.con, e.v, e.rd,
                     e.rw, e.mr, e.rtf, e.st);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
      set_fwd(0, 0, 0, 0, 0, 0);
      tick();
      push_exp("reset", 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
      tick();
      rst_n = 1'b1;
      set_id(1, 1, 2, 3, 32'd5, 32'd7, 0, 0, 4'h0, 1, 0);
      push_exp("release", 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
      tick();
      set_id(1, 3, 4, 5, 32'hAA, 32'hBB, 0, 0, 4'h2, 1, 0);
      push_exp("plain_issue", 32'd5, 32'd7, 4'h0, 1, 3, 1, 0, 32'd7, 0);
      tick();
      set_fwd(3, 1, 32'h11, 3, 1, 32'h22);
      push_exp("fwd_mem_prio", 32'h11, 32'hBB, 4'h2, 1, 5, 1, 0, 32'hBB, 0);
      tick();
      mem_reg_write = 1'b0;
      set_id(1, 0, 0, 6, 0, 0, 0, 0, 4'h1, 1, 0);
      push_exp("fwd_wb", 32'h22, 32'hBB, 4'h2, 1, 5, 1, 0, 32'hBB, 0);
      tick();
      set_fwd(0, 1, 32'hFF, 0, 1, 32'hEE);
      set_id(1, 1, 4, 4, 32'h100, 0, 32'd8, 1, 4'h0, 1, 1);
      push_exp("reg0_nofwd", 0, 0, 4'h1, 1, 6, 1, 0, 0, 0);
      tick();
      set_fwd(0, 0, 0, 0, 0, 0);
      set_id(1, 4, 2, 7, 32'h55, 32'h66, 0, 0, 4'h0, 1, 0);
      push_exp("loaduse_stall", 32'h100, 32'd8, 4'h0, 1, 4, 1, 1, 0, 1);
      tick();
      set_fwd(4, 1, 32'h1234, 0, 0, 0);
      push_exp("loaduse_bubble", 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
      tick();
      set_fwd(0, 0, 0, 4, 1, 32'h1234);
      set_id(1, 1, 9, 8, 32'h10, 32'h3, 32'hFFFF_FFFC, 1, 4'h0, 0, 0);
      push_exp("loaduse_wbfwd", 32'h1234, 32'h66, 4'h0, 1, 7, 1, 0, 32'h66, 0);
      tick();
      set_fwd(9, 1, 32'd9, 0, 0, 0);
      set_id(1, 2, 3, 10, 32'd1, 32'd2, 0, 0, 4'h8, 1, 0);
      flush = 1'b1;
      push_exp("imm_store", 32'h10, 32'hFFFF_FFFC, 4'h0, 1, 8, 0, 0, 32'd9, 0);
      tick();
      flush = 1'b0;
      set_fwd(0, 0, 0, 0, 0, 0);
      set_id(1, 0, 5, 5, 0, 0, 32'd4, 1, 4'h0, 1, 1);
      push_exp("flush_bubble", 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
      tick();
      set_id(1, 1, 5, 6, 32'h77, 32'h88, 0, 0, 4'h3, 1, 0);
      flush = 1'b1;
      push_exp("flush_and_stall", 0, 32'd4, 4'h0, 1, 5, 1, 1, 0, 1);
      tick();
      flush = 1'b0;
      set_id(1, 0, 0, 6, 0, 0, 0, 1, 4'h0, 1, 1);
      push_exp("flush_wins", 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
      tick();
      set_id(1, 1, 6, 2, 32'h3, 0, 32'h20, 1, 4'h0, 1, 0);
      push_exp("imm_masks_rt", 0, 0, 4'h0, 1, 6, 1, 1, 0, 0);
      tick();
      set_id(0, 1, 6, 3, 32'h3, 0, 32'h20, 1, 4'h0, 1, 1);
      push_exp("no_stall_imm", 32'h3, 32'h20, 4'h0, 1, 2, 1, 0, 0, 0);
      tick();
      set_id(1, 1, 2, 9, 32'h9, 32'hA, 0, 0, 4'h5, 1, 0);
      push_exp("invalid_ctrl", 32'h3, 32'h20, 4'h0, 0, 3, 0, 0, 0, 0);
      tick();
      push_exp("async_reset", 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
      #1 rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: run exceeded time limit, want completion");
      $fatal(1);
   end

endmodule
